// File: rtl/eth_phy_link_ctrl.sv
// Link bring-up and supervision FSM for eth_phy_10g in the rx_clk domain.
// Optional PRBS31 self-test is compiled in when PRBS_SELFTEST_EN is defined.
module eth_phy_link_ctrl #(
  parameter int RESET_CYCLES     = 16,
  parameter int LOCK_TIMEOUT     = 1024,
  parameter int STABLE_CYCLES    = 125,
  parameter int MAX_RETRIES      = 4,
  parameter int ERR_CNT_WIDTH    = 16,
  parameter int PRBS_TEST_CYCLES = 256
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     ctrl_enable,
  input  logic                     rx_block_lock,
  input  logic                     rx_high_ber,
  input  logic                     rx_status,
  input  logic                     serdes_rx_reset_req,
  input  logic [6:0]               rx_error_count,
  input  logic                     prbs_test_req,
  output logic                     phy_rst,
  output logic                     cfg_tx_prbs31_enable,
  output logic                     cfg_rx_prbs31_enable,
  output logic                     link_up,
  output logic                     link_fail,
  output logic [2:0]               state,
  output logic [3:0]               retry_count,
  output logic [7:0]               lock_loss_count,
  output logic [ERR_CNT_WIDTH-1:0] err_accum,
  output logic                     prbs_done,
  output logic                     prbs_pass
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RESET       = 3'd1,
    WAIT_LOCK   = 3'd2,
    WAIT_STABLE = 3'd3,
    LINK_UP     = 3'd4,
    FAIL        = 3'd5,
    PRBS_TEST   = 3'd6
  } state_t;

  // One shared timer serves RESET, WAIT_LOCK and PRBS_TEST, so size it for the longest.
  localparam int TMR_A   = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TMR_MAX = (TMR_A > PRBS_TEST_CYCLES) ? TMR_A : PRBS_TEST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STB_W   = $clog2(STABLE_CYCLES + 1);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PRBS_LAST = TMR_W'(PRBS_TEST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [STB_W-1:0]         stable_q, stable_d;
  logic [3:0]               retry_d;
  logic [7:0]               lock_loss_d;
  logic [ERR_CNT_WIDTH-1:0] err_d, err_sat;
  logic [ERR_CNT_WIDTH:0]   err_sum;
`ifdef PRBS_SELFTEST_EN
  logic                     done_d, pass_d;
`endif

  assign state   = state_q;
  assign err_sum = {1'b0, err_accum} + {{(ERR_CNT_WIDTH-6){1'b0}}, rx_error_count};
  assign err_sat = err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stable_d    = stable_q;
    retry_d     = retry_count;
    lock_loss_d = lock_loss_count;
    err_d       = err_accum;
`ifdef PRBS_SELFTEST_EN
    done_d      = 1'b0;
    pass_d      = prbs_pass;
`endif
    if (!ctrl_enable) begin
      state_d  = IDLE;
      timer_d  = '0;
      stable_d = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RESET;
          timer_d = '0;
        end
        RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock wins over a coincident timeout or SerDes reset request.
          if (rx_block_lock) begin
            state_d  = WAIT_STABLE;
            stable_d = '0;
          end else if (timer_q == LOCK_LAST || serdes_rx_reset_req) begin
            retry_d = retry_count + 4'd1;
            timer_d = '0;
            state_d = (retry_d == 4'(MAX_RETRIES)) ? FAIL : RESET;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        WAIT_STABLE: begin
          if (!rx_block_lock) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (rx_high_ber || !rx_status) begin
            stable_d = '0;
          end else if (stable_q == STB_LAST) begin
            state_d  = LINK_UP;
            stable_d = '0;
            err_d    = '0;
            retry_d  = '0;
          end else begin
            stable_d = stable_q + STB_W'(1);
          end
        end
        LINK_UP: begin
          err_d = err_sat;
          if (!rx_block_lock || rx_high_ber) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
            if (lock_loss_count != 8'hFF) lock_loss_d = lock_loss_count + 8'd1;
          end
`ifdef PRBS_SELFTEST_EN
          else if (prbs_test_req) begin
            state_d = PRBS_TEST;
            timer_d = '0;
            err_d   = '0;
            pass_d  = 1'b0;
          end
`endif
        end
        FAIL: state_d = FAIL;
`ifdef PRBS_SELFTEST_EN
        PRBS_TEST: begin
          err_d = err_sat;
          if (!rx_block_lock) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end else if (timer_q == PRBS_LAST) begin
            state_d  = WAIT_STABLE;
            stable_d = '0;
            done_d   = 1'b1;
            pass_d   = (err_sat == '0);
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      stable_q        <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      err_accum       <= '0;
      phy_rst         <= 1'b1;
      link_up         <= 1'b0;
      link_fail       <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      stable_q        <= stable_d;
      retry_count     <= retry_d;
      lock_loss_count <= lock_loss_d;
      err_accum       <= err_d;
      phy_rst         <= (state_d == IDLE) || (state_d == RESET) || (state_d == FAIL);
      link_up         <= (state_d == LINK_UP);
      link_fail       <= (state_d == FAIL);
    end
  end

`ifdef PRBS_SELFTEST_EN
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      cfg_tx_prbs31_enable <= 1'b0;
      cfg_rx_prbs31_enable <= 1'b0;
      prbs_done            <= 1'b0;
      prbs_pass            <= 1'b0;
    end else begin
      cfg_tx_prbs31_enable <= (state_d == PRBS_TEST);
      cfg_rx_prbs31_enable <= (state_d == PRBS_TEST);
      prbs_done            <= done_d;
      prbs_pass            <= pass_d;
    end
  end
`else
  logic unused_prbs_req;
  assign unused_prbs_req      = prbs_test_req;
  assign cfg_tx_prbs31_enable = 1'b0;
  assign cfg_rx_prbs31_enable = 1'b0;
  assign prbs_done            = 1'b0;
  assign prbs_pass            = 1'b0;
`endif

endmodule

// File: tb/tb_eth_phy_link_ctrl.sv
// Directed self-checking bench for eth_phy_link_ctrl (default parameters).
// Build with PRBS_SELFTEST_EN defined to exercise the self-test path.
module tb_eth_phy_link_ctrl;

  logic        rx_clk_tb;
  logic        rx_rst_tb;
  logic        ctrl_enable;
  logic        rx_block_lock;
  logic        rx_high_ber;
  logic        rx_status;
  logic        serdes_rx_reset_req;
  logic [6:0]  rx_error_count;
  logic        prbs_test_req;
  logic        phy_rst;
  logic        cfg_tx_prbs31_enable;
  logic        cfg_rx_prbs31_enable;
  logic        link_up;
  logic        link_fail;
  logic [2:0]  state;
  logic [3:0]  retry_count;
  logic [7:0]  lock_loss_count;
  logic [15:0] err_accum;
  logic        prbs_done;
  logic        prbs_pass;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ctrl_enable;
    logic        block_lock;
    logic        high_ber;
    logic        status;
    logic        serdes_req;
    logic [6:0]  err_in;
    logic [2:0]  exp_state;
    logic        exp_link_up;
    logic        exp_phy_rst;
    logic [3:0]  exp_retry;
    logic [7:0]  exp_lock_loss;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  eth_phy_link_ctrl dut (
    .rx_clk               (rx_clk_tb),
    .rx_rst_n             (rx_rst_tb),
    .ctrl_enable          (ctrl_enable),
    .rx_block_lock        (rx_block_lock),
    .rx_high_ber          (rx_high_ber),
    .rx_status            (rx_status),
    .serdes_rx_reset_req  (serdes_rx_reset_req),
    .rx_error_count       (rx_error_count),
    .prbs_test_req        (prbs_test_req),
    .phy_rst              (phy_rst),
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable),
    .link_up              (link_up),
    .link_fail            (link_fail),
    .state                (state),
    .retry_count          (retry_count),
    .lock_loss_count      (lock_loss_count),
    .err_accum            (err_accum),
    .prbs_done            (prbs_done),
    .prbs_pass            (prbs_pass)
  );

  initial rx_clk_tb = 1'b0;
  always #5 rx_clk_tb = ~rx_clk_tb;

  task automatic tick();
    @(posedge rx_clk_tb);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ctrl_enable         = v.ctrl_enable;
    rx_block_lock       = v.block_lock;
    rx_high_ber         = v.high_ber;
    rx_status           = v.status;
    serdes_rx_reset_req = v.serdes_req;
    rx_error_count      = v.err_in;
    tick();
  endtask

  // Steps the clock until state reaches target, reporting the number of edges taken.
  task automatic waitState(input string name, input int target, input int budget, output int cycles);
    cycles = 0;
    while (int'(state) != target && cycles < budget) begin
      tick();
      cycles++;
    end
    if (int'(state) != target) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual_state=%0d expected_state=%0d", name, state, target);
    end
  endtask

  initial begin
    int n;
    int exp_err;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd5,  3'd4, 1'b1, 1'b0, 4'd0, 8'd0, 16'd5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd10, 3'd4, 1'b1, 1'b0, 4'd0, 8'd0, 16'd15};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0,  3'd4, 1'b1, 1'b0, 4'd0, 8'd0, 16'd15};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0,  3'd2, 1'b0, 1'b0, 4'd0, 8'd1, 16'd15};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0,  3'd3, 1'b0, 1'b0, 4'd0, 8'd1, 16'd15};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0,  3'd3, 1'b0, 1'b0, 4'd0, 8'd1, 16'd15};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,  3'd3, 1'b0, 1'b0, 4'd0, 8'd1, 16'd15};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0,  3'd2, 1'b0, 1'b0, 4'd0, 8'd1, 16'd15};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0,  3'd1, 1'b0, 1'b1, 4'd1, 8'd1, 16'd15};

    rx_rst_tb           = 1'b0;
    ctrl_enable         = 1'b0;
    rx_block_lock       = 1'b0;
    rx_high_ber         = 1'b0;
    rx_status           = 1'b1;
    serdes_rx_reset_req = 1'b0;
    rx_error_count      = 7'd0;
    prbs_test_req       = 1'b0;
    repeat (3) tick();

    checkOutput("rst_state", state, 0);
    checkOutput("rst_phy_rst", phy_rst, 1);
    checkOutput("rst_link_up", link_up, 0);
    checkOutput("rst_link_fail", link_fail, 0);
    checkOutput("rst_retry", retry_count, 0);
    checkOutput("rst_lock_loss", lock_loss_count, 0);
    checkOutput("rst_err", err_accum, 0);
    checkOutput("rst_prbs_en", {cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, prbs_done, prbs_pass}, 0);

    // Bring-up: lock appears on the 10th WAIT_LOCK cycle.
    ctrl_enable = 1'b1;
    rx_rst_tb   = 1'b1;
    tick();
    checkOutput("t1_state_reset", state, 1);
    checkOutput("t1_phy_rst_hi", phy_rst, 1);
    waitState("t1_reset_len", 2, 100, n);
    checkOutput("t1_reset_cycles", n, 16);
    checkOutput("t1_phy_rst_lo", phy_rst, 0);
    repeat (9) tick();
    checkOutput("t1_still_wait_lock", state, 2);
    rx_block_lock = 1'b1;
    tick();
    checkOutput("t1_wait_stable", state, 3);
    waitState("t1_stable_len", 4, 300, n);
    checkOutput("t1_stable_cycles", n, 125);
    checkOutput("t1_link_up", link_up, 1);
    checkOutput("t1_retry", retry_count, 0);

    // LINK_UP accumulation, lock loss, stability disqualifiers and a SerDes-forced retry.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      checkOutput($sformatf("vec%0d_link_up", i), link_up, vecs[i].exp_link_up);
      checkOutput($sformatf("vec%0d_phy_rst", i), phy_rst, vecs[i].exp_phy_rst);
      checkOutput($sformatf("vec%0d_retry", i), retry_count, vecs[i].exp_retry);
      checkOutput($sformatf("vec%0d_lock_loss", i), lock_loss_count, vecs[i].exp_lock_loss);
      checkOutput($sformatf("vec%0d_err", i), err_accum, vecs[i].exp_err);
    end
    serdes_rx_reset_req = 1'b0;

    // High BER on qualifying cycle 100 restarts the stability window.
    rx_block_lock = 1'b1;
    waitState("t4_to_stable", 3, 100, n);
    repeat (99) tick();
    rx_high_ber = 1'b1;
    tick();
    checkOutput("t4_held_state", state, 3);
    rx_high_ber = 1'b0;
    waitState("t4_requalify", 4, 300, n);
    checkOutput("t4_stable_cycles", n, 125);
    checkOutput("t4_link_up", link_up, 1);
    checkOutput("t4_retry_cleared", retry_count, 0);
    checkOutput("t4_err_cleared", err_accum, 0);

    // Single-cycle lock drop in LINK_UP.
    rx_block_lock = 1'b0;
    tick();
    checkOutput("t3_state", state, 2);
    checkOutput("t3_link_up", link_up, 0);
    checkOutput("t3_lock_loss", lock_loss_count, 2);
    checkOutput("t3_phy_rst", phy_rst, 0);
    rx_block_lock = 1'b1;
    tick();
    checkOutput("t3_wait_stable", state, 3);
    waitState("t3_requalify", 4, 300, n);
    checkOutput("t3_stable_cycles", n, 125);

    // Error accumulation saturates at cycle 517.
    rx_error_count = 7'd127;
    for (int k = 1; k <= 520; k++) begin
      tick();
      exp_err = (127 * k > 65535) ? 65535 : 127 * k;
      checkOutput($sformatf("t5_err_n%0d", k), err_accum, exp_err);
    end
    rx_error_count = 7'd0;

`ifdef PRBS_SELFTEST_EN
    prbs_test_req = 1'b1;
    tick();
    prbs_test_req = 1'b0;
    checkOutput("t6_state_prbs", state, 6);
    checkOutput("t6_link_up", link_up, 0);
    checkOutput("t6_err_cleared", err_accum, 0);
    n = 0;
    while ((cfg_tx_prbs31_enable && cfg_rx_prbs31_enable) && n < 1000) begin
      n++;
      tick();
    end
    checkOutput("t6_en_cycles", n, 256);
    checkOutput("t6_done", prbs_done, 1);
    checkOutput("t6_pass", prbs_pass, 1);
    checkOutput("t6_state_after", state, 3);
    tick();
    checkOutput("t6_done_pulse", prbs_done, 0);
    checkOutput("t6_pass_held", prbs_pass, 1);
    waitState("t6_requalify", 4, 300, n);
    checkOutput("t6_stable_cycles", n, 125);
    prbs_test_req = 1'b1;
    tick();
    prbs_test_req = 1'b0;
    checkOutput("t6b_state_prbs", state, 6);
    checkOutput("t6b_pass_cleared", prbs_pass, 0);
    repeat (10) tick();
    rx_error_count = 7'd3;
    tick();
    rx_error_count = 7'd0;
    n = 0;
    while (!prbs_done && n < 1000) begin
      n++;
      tick();
    end
    checkOutput("t6b_done", prbs_done, 1);
    checkOutput("t6b_pass", prbs_pass, 0);
    checkOutput("t6b_err", err_accum, 3);
    checkOutput("t6b_state_after", state, 3);
`else
    prbs_test_req = 1'b1;
    tick();
    prbs_test_req = 1'b0;
    checkOutput("t6_state_stays", state, 4);
    checkOutput("t6_en_off", {cfg_tx_prbs31_enable, cfg_rx_prbs31_enable}, 0);
    repeat (5) tick();
    checkOutput("t6_state_later", state, 4);
    checkOutput("t6_done_pass_off", {prbs_done, prbs_pass}, 0);
`endif

    // ctrl_enable dropped mid-WAIT_LOCK with a nonzero retry count.
    ctrl_enable = 1'b0;
    tick();
    checkOutput("t5b_idle", state, 0);
    rx_block_lock = 1'b0;
    ctrl_enable   = 1'b1;
    waitState("t5b_to_wait_lock", 2, 100, n);
    repeat (3) tick();
    serdes_rx_reset_req = 1'b1;
    tick();
    serdes_rx_reset_req = 1'b0;
    checkOutput("t5b_retry_state", state, 1);
    checkOutput("t5b_retry_count", retry_count, 1);
    waitState("t5b_wait_lock2", 2, 100, n);
    repeat (5) tick();
    ctrl_enable = 1'b0;
    tick();
    checkOutput("t5b_state_idle", state, 0);
    checkOutput("t5b_phy_rst", phy_rst, 1);
    checkOutput("t5b_retry_cleared", retry_count, 0);

    // Lock arriving on the final timeout cycle wins over the retry.
    ctrl_enable = 1'b1;
    waitState("tb_to_wait_lock", 2, 100, n);
    repeat (1023) tick();
    checkOutput("lock_edge_state", state, 2);
    rx_block_lock = 1'b1;
    tick();
    checkOutput("lock_edge_stable", state, 3);
    checkOutput("lock_edge_retry", retry_count, 0);

    // Retries exhausted.
    ctrl_enable = 1'b0;
    tick();
    rx_block_lock = 1'b0;
    ctrl_enable   = 1'b1;
    tick();
    checkOutput("t2_state_reset", state, 1);
    waitState("t2_to_fail", 5, 6000, n);
    checkOutput("t2_cycles", n, 4160);
    checkOutput("t2_link_fail", link_fail, 1);
    checkOutput("t2_retry", retry_count, 4);
    checkOutput("t2_phy_rst", phy_rst, 1);
    repeat (3) tick();
    checkOutput("t2_fail_held", state, 5);
    ctrl_enable = 1'b0;
    tick();
    checkOutput("t2_idle", state, 0);
    checkOutput("t2_link_fail_clr", link_fail, 0);
    checkOutput("t2_retry_clr", retry_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
